// File: rtl/pipe_run_monitor_if.sv
// Observation bundle from the pipelined core's hazard unit and M/W stages.
// The core side drives it (master); the run monitor only listens (slave).
interface pipe_run_monitor_if #(
    parameter int WIDTH   = 32,
    parameter int NUM_FWD = 2
);
    logic                   stall_f;
    logic                   stall_d;
    logic                   flush_e;
    logic                   reg_write_w;
    logic                   mem_write_m;
    logic [WIDTH-1:0]       alu_out_m;
    logic [WIDTH-1:0]       write_data_m;
    logic [2*NUM_FWD-1:0]   fwd;

    modport master (
        output stall_f, stall_d, flush_e, reg_write_w,
        output mem_write_m, alu_out_m, write_data_m, fwd
    );

    modport slave (
        input stall_f, stall_d, flush_e, reg_write_w,
        input mem_write_m, alu_out_m, write_data_m, fwd
    );
endinterface

// File: rtl/pipe_run_monitor.sv
// Run controller and performance monitor for the pipelined MIPS core: sequences
// core reset, counts RUN-cycle events, and latches halt/timeout with pass/fail.
module pipe_run_monitor #(
    parameter int               WIDTH        = 32,
    parameter int               CNT_W        = 32,
    parameter int               NUM_FWD      = 2,
    parameter int               RESET_CYCLES = 4,
    parameter longint           MAX_CYCLES   = 100000,
    parameter logic [WIDTH-1:0] HALT_ADDR    = 32'h0000_0054,
    parameter logic [WIDTH-1:0] PASS_VALUE   = 32'h0000_0007
) (
    input  logic                     clk,
    input  logic                     reset,
    pipe_run_monitor_if.slave        obs,
    output logic                     core_reset,
    output logic [1:0]               state,
    output logic                     done,
    output logic                     pass,
    output logic [CNT_W-1:0]         cnt_cycle,
    output logic [CNT_W-1:0]         cnt_retire,
    output logic [CNT_W-1:0]         cnt_stall,
    output logic [CNT_W-1:0]         cnt_flush,
    output logic [NUM_FWD*CNT_W-1:0] cnt_fwd_m,
    output logic [NUM_FWD*CNT_W-1:0] cnt_fwd_w,
    output logic                     fwd_err
);

    localparam logic [1:0] S_HOLD    = 2'd0;
    localparam logic [1:0] S_RUN     = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;
    localparam logic [1:0] S_TIMEOUT = 2'd3;

    localparam int                HOLD_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);

    // Timeout compare is done one bit wider than the larger of CNT_W and 32 so a
    // saturated counter can never alias onto the budget.
    localparam int               CMP_W       = ((CNT_W > 32) ? CNT_W : 32) + 1;
    localparam logic [CMP_W-1:0] CYCLE_LIMIT = CMP_W'(MAX_CYCLES);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != {CNT_W{1'b1}}))
            return v + CNT_W'(1);
        return v;
    endfunction

    logic [1:0]                          state_q, state_d;
    logic [HOLD_W-1:0]                   hold_q, hold_d;
    logic                                core_reset_q, core_reset_d;
    logic                                done_q, done_d;
    logic                                pass_q, pass_d;
    logic [CNT_W-1:0]                    cnt_cycle_q, cnt_cycle_d;
    logic [CNT_W-1:0]                    cnt_retire_q, cnt_retire_d;
    logic [CNT_W-1:0]                    cnt_stall_q, cnt_stall_d;
    logic [CNT_W-1:0]                    cnt_flush_q, cnt_flush_d;
    logic [NUM_FWD-1:0][CNT_W-1:0]       cnt_fwd_m_q, cnt_fwd_m_d;
    logic [NUM_FWD-1:0][CNT_W-1:0]       cnt_fwd_w_q, cnt_fwd_w_d;
    logic                                fwd_err_q, fwd_err_d;

    logic                                halt;
    logic                                timeout_hit;
    logic [1:0]                          fwd_sel;

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        pass_d       = pass_q;
        cnt_cycle_d  = cnt_cycle_q;
        cnt_retire_d = cnt_retire_q;
        cnt_stall_d  = cnt_stall_q;
        cnt_flush_d  = cnt_flush_q;
        cnt_fwd_m_d  = cnt_fwd_m_q;
        cnt_fwd_w_d  = cnt_fwd_w_q;
        fwd_err_d    = fwd_err_q;
        fwd_sel      = 2'b00;

        halt        = obs.mem_write_m && (obs.alu_out_m == HALT_ADDR);
        timeout_hit = (({{(CMP_W-CNT_W){1'b0}}, cnt_cycle_q} + CMP_W'(1)) == CYCLE_LIMIT);

        case (state_q)
            S_HOLD: begin
                if (hold_q == HOLD_LAST)
                    state_d = S_RUN;
                else
                    hold_d = hold_q + HOLD_W'(1);
            end
            S_RUN: begin
                cnt_cycle_d  = sat_inc(cnt_cycle_q, 1'b1);
                cnt_retire_d = sat_inc(cnt_retire_q, obs.reg_write_w);
                cnt_stall_d  = sat_inc(cnt_stall_q, obs.stall_f | obs.stall_d);
                cnt_flush_d  = sat_inc(cnt_flush_q, obs.flush_e);
                for (int i = 0; i < NUM_FWD; i++) begin
                    fwd_sel        = obs.fwd[2*i +: 2];
                    cnt_fwd_m_d[i] = sat_inc(cnt_fwd_m_q[i], fwd_sel == 2'b10);
                    cnt_fwd_w_d[i] = sat_inc(cnt_fwd_w_q[i], fwd_sel == 2'b01);
                    if (fwd_sel == 2'b11)
                        fwd_err_d = 1'b1;
                end
                // Halt outranks timeout when both land on the same cycle.
                if (halt) begin
                    state_d = S_DONE;
                    pass_d  = (obs.write_data_m == PASS_VALUE);
                end else if (timeout_hit) begin
                    state_d = S_TIMEOUT;
                end
            end
            default: ;
        endcase

        core_reset_d = (state_d != S_RUN);
        done_d       = (state_d == S_DONE) || (state_d == S_TIMEOUT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_HOLD;
            hold_q       <= '0;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            cnt_cycle_q  <= '0;
            cnt_retire_q <= '0;
            cnt_stall_q  <= '0;
            cnt_flush_q  <= '0;
            cnt_fwd_m_q  <= '0;
            cnt_fwd_w_q  <= '0;
            fwd_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            core_reset_q <= core_reset_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            cnt_cycle_q  <= cnt_cycle_d;
            cnt_retire_q <= cnt_retire_d;
            cnt_stall_q  <= cnt_stall_d;
            cnt_flush_q  <= cnt_flush_d;
            cnt_fwd_m_q  <= cnt_fwd_m_d;
            cnt_fwd_w_q  <= cnt_fwd_w_d;
            fwd_err_q    <= fwd_err_d;
        end
    end

    assign core_reset = core_reset_q;
    assign state      = state_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign cnt_cycle  = cnt_cycle_q;
    assign cnt_retire = cnt_retire_q;
    assign cnt_stall  = cnt_stall_q;
    assign cnt_flush  = cnt_flush_q;
    assign cnt_fwd_m  = cnt_fwd_m_q;
    assign cnt_fwd_w  = cnt_fwd_w_q;
    assign fwd_err    = fwd_err_q;

endmodule

// File: tb/tb_pipe_run_monitor.sv
// Bench for pipe_run_monitor: two instances (short timeout / 4-bit counters)
// share one observation bus and are compared against an event-level model.
module tb_pipe_run_monitor;

    localparam logic [31:0] HALT = 32'h0000_0054;
    localparam logic [31:0] PASSV = 32'h0000_0007;

    logic clk = 1'b0;
    logic reset_a;
    logic reset_s;
    always #5 clk = ~clk;

    pipe_run_monitor_if #(.WIDTH(32), .NUM_FWD(2)) obs_if ();

    logic        a_core_reset, a_done, a_pass, a_fwd_err;
    logic [1:0]  a_state;
    logic [31:0] a_cyc, a_ret, a_stl, a_fl;
    logic [63:0] a_fm, a_fw;

    logic        s_core_reset, s_done, s_pass, s_fwd_err;
    logic [1:0]  s_state;
    logic [3:0]  s_cyc, s_ret, s_stl, s_fl;
    logic [7:0]  s_fm, s_fw;

    pipe_run_monitor #(.WIDTH(32), .CNT_W(32), .NUM_FWD(2), .RESET_CYCLES(4),
                       .MAX_CYCLES(20)) dut_a (
        .clk(clk), .reset(reset_a), .obs(obs_if),
        .core_reset(a_core_reset), .state(a_state), .done(a_done), .pass(a_pass),
        .cnt_cycle(a_cyc), .cnt_retire(a_ret), .cnt_stall(a_stl), .cnt_flush(a_fl),
        .cnt_fwd_m(a_fm), .cnt_fwd_w(a_fw), .fwd_err(a_fwd_err)
    );

    pipe_run_monitor #(.WIDTH(32), .CNT_W(4), .NUM_FWD(2), .RESET_CYCLES(1)) dut_s (
        .clk(clk), .reset(reset_s), .obs(obs_if),
        .core_reset(s_core_reset), .state(s_state), .done(s_done), .pass(s_pass),
        .cnt_cycle(s_cyc), .cnt_retire(s_ret), .cnt_stall(s_stl), .cnt_flush(s_fl),
        .cnt_fwd_m(s_fm), .cnt_fwd_w(s_fw), .fwd_err(s_fwd_err)
    );

    // Stimulus values for the next cycle; applied on the falling edge.
    logic        drv_rst_a, drv_rst_s;
    logic        drv_sf, drv_sd, drv_fe, drv_rw, drv_mw;
    logic [31:0] drv_addr, drv_data;
    logic [3:0]  drv_fwd;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // st: 0 hold, 1 run, 2 done, 3 timeout; hold = edges seen since release.
    typedef struct {
        int     st;
        int     hold;
        longint cyc, ret, stl, fl, fm0, fm1, fw0, fw1;
        bit     err, pass;
    } model_t;

    model_t ma, ms;

    function automatic model_t model_reset();
        model_t m;
        m.st = 0; m.hold = 0;
        m.cyc = 0; m.ret = 0; m.stl = 0; m.fl = 0;
        m.fm0 = 0; m.fm1 = 0; m.fw0 = 0; m.fw1 = 0;
        m.err = 1'b0; m.pass = 1'b0;
        return m;
    endfunction

    function automatic longint bump(longint v, bit en, longint mx);
        if (en && v < mx) return v + 1;
        return v;
    endfunction

    function automatic model_t model_edge(model_t m, int rc, longint maxc, longint mx);
        bit halt;
        if (m.st == 0) begin
            m.hold++;
            if (m.hold == rc) m.st = 1;
        end else if (m.st == 1) begin
            halt  = drv_mw && (drv_addr == HALT);
            m.cyc = bump(m.cyc, 1'b1, mx);
            m.ret = bump(m.ret, drv_rw, mx);
            m.stl = bump(m.stl, drv_sf || drv_sd, mx);
            m.fl  = bump(m.fl, drv_fe, mx);
            m.fm0 = bump(m.fm0, drv_fwd[1:0] == 2'b10, mx);
            m.fw0 = bump(m.fw0, drv_fwd[1:0] == 2'b01, mx);
            m.fm1 = bump(m.fm1, drv_fwd[3:2] == 2'b10, mx);
            m.fw1 = bump(m.fw1, drv_fwd[3:2] == 2'b01, mx);
            if (drv_fwd[1:0] == 2'b11 || drv_fwd[3:2] == 2'b11) m.err = 1'b1;
            if (halt) begin
                m.st   = 2;
                m.pass = (drv_data == PASSV);
            end else if (m.cyc == maxc) begin
                m.st = 3;
            end
        end
        return m;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic check_a();
        chk("a.state", 64'(a_state), 64'(ma.st));
        chk("a.core_reset", 64'(a_core_reset), 64'(ma.st != 1));
        chk("a.done", 64'(a_done), 64'(ma.st >= 2));
        chk("a.pass", 64'(a_pass), 64'(ma.pass));
        chk("a.cnt_cycle", 64'(a_cyc), 64'(ma.cyc));
        chk("a.cnt_retire", 64'(a_ret), 64'(ma.ret));
        chk("a.cnt_stall", 64'(a_stl), 64'(ma.stl));
        chk("a.cnt_flush", 64'(a_fl), 64'(ma.fl));
        chk("a.fwd_m0", 64'(a_fm[31:0]), 64'(ma.fm0));
        chk("a.fwd_m1", 64'(a_fm[63:32]), 64'(ma.fm1));
        chk("a.fwd_w0", 64'(a_fw[31:0]), 64'(ma.fw0));
        chk("a.fwd_w1", 64'(a_fw[63:32]), 64'(ma.fw1));
        chk("a.fwd_err", 64'(a_fwd_err), 64'(ma.err));
    endtask

    task automatic check_s();
        chk("s.state", 64'(s_state), 64'(ms.st));
        chk("s.core_reset", 64'(s_core_reset), 64'(ms.st != 1));
        chk("s.done", 64'(s_done), 64'(ms.st >= 2));
        chk("s.pass", 64'(s_pass), 64'(ms.pass));
        chk("s.cnt_cycle", 64'(s_cyc), 64'(ms.cyc));
        chk("s.cnt_retire", 64'(s_ret), 64'(ms.ret));
        chk("s.cnt_stall", 64'(s_stl), 64'(ms.stl));
        chk("s.cnt_flush", 64'(s_fl), 64'(ms.fl));
        chk("s.fwd_m0", 64'(s_fm[3:0]), 64'(ms.fm0));
        chk("s.fwd_m1", 64'(s_fm[7:4]), 64'(ms.fm1));
        chk("s.fwd_w0", 64'(s_fw[3:0]), 64'(ms.fw0));
        chk("s.fwd_w1", 64'(s_fw[7:4]), 64'(ms.fw1));
        chk("s.fwd_err", 64'(s_fwd_err), 64'(ms.err));
    endtask

    // One clock: apply stimulus at the falling edge, advance models at the
    // rising edge, compare 1 time unit later.
    task automatic step();
        @(negedge clk);
        reset_a             = drv_rst_a;
        reset_s             = drv_rst_s;
        obs_if.stall_f      = drv_sf;
        obs_if.stall_d      = drv_sd;
        obs_if.flush_e      = drv_fe;
        obs_if.reg_write_w  = drv_rw;
        obs_if.mem_write_m  = drv_mw;
        obs_if.alu_out_m    = drv_addr;
        obs_if.write_data_m = drv_data;
        obs_if.fwd          = drv_fwd;
        @(posedge clk);
        ma = drv_rst_a ? model_edge(ma, 4, 20, 64'hFFFF_FFFF) : model_reset();
        ms = drv_rst_s ? model_edge(ms, 1, 100000, 15) : model_reset();
        #1;
        check_a();
        check_s();
    endtask

    function automatic logic [1:0] rand_sel(bit allow_11);
        int r;
        r = $urandom_range(0, allow_11 ? 3 : 2);
        case (r)
            0: return 2'b00;
            1: return 2'b10;
            2: return 2'b01;
            default: return 2'b11;
        endcase
    endfunction

    task automatic drive_rand(input bit allow_halt, input bit allow_11);
        int r;
        drv_sf  = 1'($urandom_range(0, 1));
        drv_sd  = 1'($urandom_range(0, 1));
        drv_fe  = 1'($urandom_range(0, 1));
        drv_rw  = 1'($urandom_range(0, 1));
        drv_mw  = 1'($urandom_range(0, 1));
        drv_fwd = {rand_sel(allow_11), rand_sel(allow_11)};
        r = $urandom_range(0, 2);
        if (r == 0) drv_addr = 32'h0000_0050;
        else if (r == 2 && allow_halt) drv_addr = HALT;
        else begin
            drv_addr = $urandom;
            if (drv_addr == HALT) drv_addr = 32'h0000_0058;
        end
        drv_data = ($urandom_range(0, 1) == 1) ? PASSV : $urandom;
    endtask

    task automatic drive_halt(input logic [31:0] data);
        drive_rand(1'b0, 1'b0);
        drv_mw   = 1'b1;
        drv_addr = HALT;
        drv_data = data;
    endtask

    // Reset dut_a, walk through its 4-cycle hold, ready for RUN stimulus.
    task automatic restart_a();
        drv_rst_a = 1'b0;
        drive_rand(1'b1, 1'b1);
        step();
        drv_rst_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_halt(PASSV);
            step();
        end
    endtask

    logic [9:0] pat_rw, pat_st, pat_fl, pat_fm, pat_fw;

    initial begin
        reset_a = 1'b0;
        reset_s = 1'b0;
        ma = model_reset();
        ms = model_reset();
        drv_rst_a = 1'b0;
        drv_rst_s = 1'b0;
        drive_rand(1'b1, 1'b1);

        // Reset held low for two cycles.
        step();
        step();

        // Release: four hold edges with a passing halt store that must be ignored.
        drv_rst_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("hold.core_reset_before_edge", 64'(a_core_reset), 64'd1);
            drive_halt(PASSV);
            step();
        end
        chk("hold.entered_run", 64'(a_state), 64'd1);
        chk("hold.cycle_zero", 64'(a_cyc), 64'd0);

        // Directed counting pattern over 10 RUN cycles.
        pat_rw = 10'b1110110100;
        pat_st = 10'b0100100100;
        pat_fl = 10'b0000100001;
        pat_fm = 10'b1010101000;
        pat_fw = 10'b0000000100;
        for (int i = 0; i < 10; i++) begin
            drv_rw   = pat_rw[i];
            drv_sf   = pat_st[i];
            drv_sd   = pat_st[i];
            drv_fe   = pat_fl[i];
            drv_fwd  = {2'b00, pat_fm[i], pat_fw[i]};
            drv_mw   = 1'b0;
            drv_addr = HALT;
            drv_data = PASSV;
            step();
        end
        chk("count.cycle", 64'(a_cyc), 64'd10);
        chk("count.retire", 64'(a_ret), 64'd6);
        chk("count.stall", 64'(a_stl), 64'd3);
        chk("count.flush", 64'(a_fl), 64'd2);
        chk("count.fwd_m0", 64'(a_fm[31:0]), 64'd4);
        chk("count.fwd_w0", 64'(a_fw[31:0]), 64'd1);
        chk("count.fwd_m1", 64'(a_fm[63:32]), 64'd0);

        // Store to a neighbouring address, then random non-halting traffic.
        drive_rand(1'b0, 1'b0);
        drv_mw   = 1'b1;
        drv_addr = 32'h0000_0050;
        drv_data = PASSV;
        step();
        chk("store50.still_run", 64'(a_state), 64'd1);
        for (int i = 0; i < 4; i++) begin
            drive_rand(1'b0, 1'b0);
            step();
        end

        // Passing halt on RUN cycle 16.
        drive_halt(PASSV);
        step();
        chk("halt_pass.state", 64'(a_state), 64'd2);
        chk("halt_pass.pass", 64'(a_pass), 64'd1);
        chk("halt_pass.cycle", 64'(a_cyc), 64'd16);
        for (int i = 0; i < 3; i++) begin
            drive_rand(1'b1, 1'b1);
            step();
        end
        chk("halt_pass.frozen", 64'(a_cyc), 64'd16);

        // Failing halt with data 5.
        restart_a();
        for (int i = 0; i < 6; i++) begin
            drive_rand(1'b0, 1'b1);
            step();
        end
        drive_halt(32'd5);
        step();
        chk("halt_fail.state", 64'(a_state), 64'd2);
        chk("halt_fail.pass", 64'(a_pass), 64'd0);
        drive_rand(1'b1, 1'b1);
        step();

        // Timeout after 20 RUN cycles.
        restart_a();
        for (int i = 0; i < 20; i++) begin
            drive_rand(1'b0, 1'b0);
            step();
        end
        chk("timeout.state", 64'(a_state), 64'd3);
        chk("timeout.cycle", 64'(a_cyc), 64'd20);
        chk("timeout.pass", 64'(a_pass), 64'd0);
        for (int i = 0; i < 2; i++) begin
            drive_halt(PASSV);
            step();
        end
        chk("timeout.terminal", 64'(a_state), 64'd3);

        // Halt coinciding with the timeout cycle.
        restart_a();
        for (int i = 0; i < 19; i++) begin
            drive_rand(1'b0, 1'b0);
            step();
        end
        drive_halt(PASSV);
        step();
        chk("tie.state", 64'(a_state), 64'd2);
        chk("tie.pass", 64'(a_pass), 64'd1);
        chk("tie.cycle", 64'(a_cyc), 64'd20);

        // Asynchronous reset in the middle of a RUN cycle.
        restart_a();
        for (int i = 0; i < 5; i++) begin
            drive_rand(1'b0, 1'b1);
            step();
        end
        #2;
        reset_a   = 1'b0;
        drv_rst_a = 1'b0;
        ma        = model_reset();
        #1;
        check_a();
        chk("async.core_reset", 64'(a_core_reset), 64'd1);

        // Saturation on 4-bit counters, then a sticky illegal forward select.
        drv_rst_s = 1'b1;
        for (int i = 0; i < 21; i++) begin
            drive_rand(1'b0, 1'b0);
            drv_rw = 1'b1;
            step();
        end
        chk("sat.retire", 64'(s_ret), 64'd15);
        chk("sat.cycle", 64'(s_cyc), 64'd15);
        chk("sat.state", 64'(s_state), 64'd1);
        drive_rand(1'b0, 1'b0);
        drv_fwd = 4'b0011;
        step();
        chk("err.set", 64'(s_fwd_err), 64'd1);
        for (int i = 0; i < 3; i++) begin
            drive_rand(1'b0, 1'b0);
            step();
        end
        chk("err.sticky", 64'(s_fwd_err), 64'd1);
        drv_rst_s = 1'b0;
        step();
        chk("err.cleared", 64'(s_fwd_err), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
